ipv4_rule_filter: RTL and testbench

Parametrised IPv4 filter that checks each packet's source/destination address pair against a runtime-programmable rule table. Each rule has a prefix mask, a field selector and a permit/deny action. The table is scanned LANES entries per cycle, and the lowest-indexed matching rule wins. The block sits in the PacketSentinel datapath between header extraction and the forwarding/drop stage, and exchanges valid/ready handshakes on both sides.

---
 rtl/ipv4_filter_pkg.sv | 35 +++
 rtl/ipv4_rule_match.sv | 31 +++
 rtl/ipv4_rule_filter.sv | 161 ++++++++++++++++
 tb/tb_ipv4_rule_filter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ipv4_filter_pkg.sv
// Shared types for the IPv4 rule filter: rule entry layout, field selector,
// FSM states and the prefix-length to netmask helper.
package ipv4_filter_pkg;

  typedef enum logic [1:0] {
    FIELD_SRC  = 2'b00,
    FIELD_DST  = 2'b01,
    FIELD_ANY  = 2'b10,
    FIELD_BOTH = 2'b11
  } field_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEARCH = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] ip;
    logic [5:0]  prefix;
    field_e      field;
    logic        action;
  } rule_t;

  function automatic logic [31:0] prefix_to_mask(input logic [5:0] prefix);
    if (prefix == 6'd0)
      return 32'h0;
    else if (prefix >= 6'd32)
      return 32'hFFFF_FFFF;
    else
      return 32'hFFFF_FFFF << (6'd32 - prefix);
  endfunction

endpackage

// File: rtl/ipv4_rule_match.sv
// Combinational comparator of one rule against a source/destination pair.
module ipv4_rule_match
  import ipv4_filter_pkg::*;
(
  input  rule_t       rule,
  input  logic [31:0] src,
  input  logic [31:0] dst,
  output logic        match
);

  logic [31:0] mask;
  logic        src_m;
  logic        dst_m;
  logic        sel_m;

  always_comb begin
    mask  = prefix_to_mask(rule.prefix);
    src_m = ((src ^ rule.ip) & mask) == 32'h0;
    dst_m = ((dst ^ rule.ip) & mask) == 32'h0;
    sel_m = 1'b0;
    case (rule.field)
      FIELD_SRC:  sel_m = src_m;
      FIELD_DST:  sel_m = dst_m;
      FIELD_ANY:  sel_m = src_m | dst_m;
      FIELD_BOTH: sel_m = src_m & dst_m;
      default:    sel_m = 1'b0;
    endcase
    match = rule.valid & sel_m;
  end

endmodule

// File: rtl/ipv4_rule_filter.sv
// Rule-table IPv4 filter: scans LANES rules per cycle, lowest matching index
// wins, verdict held on a valid/ready output until accepted.
module ipv4_rule_filter
  import ipv4_filter_pkg::*;
#(
  parameter int   DEPTH         = 16,
  parameter int   LANES         = 4,
  parameter logic DEFAULT_BLOCK = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              src_ip,
  input  logic [31:0]              dst_ip,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_block,
  output logic                     out_hit,
  output logic [$clog2(DEPTH)-1:0] out_rule_idx,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx,
  input  logic                     cfg_valid,
  input  logic [31:0]              cfg_ip,
  input  logic [5:0]               cfg_prefix,
  input  logic [1:0]               cfg_field,
  input  logic                     cfg_action,
  output logic [31:0]              pkt_count,
  output logic [31:0]              block_count
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int GROUPS = DEPTH / LANES;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  rule_t              rules [DEPTH];
  rule_t              new_rule;
  state_e             state_reg;
  logic [GRP_W-1:0]   group_reg;
  logic [31:0]        src_reg;
  logic [31:0]        dst_reg;
  logic               block_reg;
  logic               hit_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [31:0]        pkt_count_reg;
  logic [31:0]        block_count_reg;

  rule_t              lane_rule [LANES];
  logic [IDX_W-1:0]   lane_idx  [LANES];
  logic [LANES-1:0]   lane_match;
  logic               hit_any;
  logic [IDX_W-1:0]   win_idx;
  logic               win_action;
  logic               last_group;

  always_comb begin
    new_rule.valid  = cfg_valid;
    new_rule.ip     = cfg_ip;
    new_rule.prefix = (cfg_prefix > 6'd32) ? 6'd32 : cfg_prefix;
    new_rule.field  = field_e'(cfg_field);
    new_rule.action = cfg_action;
  end

  // Only the valid bits need clearing; stale payload is masked by valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rules[i].valid <= 1'b0;
    end else if (cfg_we) begin
      rules[cfg_idx] <= new_rule;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_idx[gi]  = IDX_W'(32'(group_reg) * LANES + gi);
      assign lane_rule[gi] = rules[lane_idx[gi]];
      ipv4_rule_match u_match (
        .rule  (lane_rule[gi]),
        .src   (src_reg),
        .dst   (dst_reg),
        .match (lane_match[gi])
      );
    end
  endgenerate

  // Descending scan so the lowest matching lane is the last to assign.
  always_comb begin
    hit_any    = 1'b0;
    win_idx    = '0;
    win_action = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_match[i]) begin
        hit_any    = 1'b1;
        win_idx    = lane_idx[i];
        win_action = lane_rule[i].action;
      end
    end
  end

  assign last_group = (group_reg == GRP_W'(GROUPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      group_reg       <= '0;
      src_reg         <= '0;
      dst_reg         <= '0;
      block_reg       <= 1'b0;
      hit_reg         <= 1'b0;
      idx_reg         <= '0;
      pkt_count_reg   <= '0;
      block_count_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            src_reg   <= src_ip;
            dst_reg   <= dst_ip;
            group_reg <= '0;
            state_reg <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (hit_any) begin
            block_reg <= win_action;
            hit_reg   <= 1'b1;
            idx_reg   <= win_idx;
            state_reg <= ST_DONE;
          end else if (last_group) begin
            block_reg <= DEFAULT_BLOCK;
            hit_reg   <= 1'b0;
            idx_reg   <= '0;
            state_reg <= ST_DONE;
          end else begin
            group_reg <= group_reg + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            if (pkt_count_reg != 32'hFFFF_FFFF)
              pkt_count_reg <= pkt_count_reg + 32'd1;
            if (block_reg && block_count_reg != 32'hFFFF_FFFF)
              block_count_reg <= block_count_reg + 32'd1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = (state_reg == ST_IDLE);
  assign out_valid    = (state_reg == ST_DONE);
  assign out_block    = block_reg;
  assign out_hit      = hit_reg;
  assign out_rule_idx = idx_reg;
  assign pkt_count    = pkt_count_reg;
  assign block_count  = block_count_reg;

endmodule

// File: tb/tb_ipv4_rule_filter.sv
// Directed bench for ipv4_rule_filter: priority, field modes, latency,
// backpressure, mid-search reset and counter saturation.
module tb_ipv4_rule_filter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic        out_valid;
  logic        out_ready;
  logic        out_block;
  logic        out_hit;
  logic [3:0]  out_rule_idx;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic        cfg_valid;
  logic [31:0] cfg_ip;
  logic [5:0]  cfg_prefix;
  logic [1:0]  cfg_field;
  logic        cfg_action;
  logic [31:0] pkt_count;
  logic [31:0] block_count;

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_pkt;
  logic [31:0] exp_blk;
  logic        last_block;
  logic        seen_valid;

  ipv4_rule_filter dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .src_ip       (src_ip),
    .dst_ip       (dst_ip),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_block    (out_block),
    .out_hit      (out_hit),
    .out_rule_idx (out_rule_idx),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_valid    (cfg_valid),
    .cfg_ip       (cfg_ip),
    .cfg_prefix   (cfg_prefix),
    .cfg_field    (cfg_field),
    .cfg_action   (cfg_action),
    .pkt_count    (pkt_count),
    .block_count  (block_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic vld, input logic [31:0] ip,
                           input logic [5:0] prefix, input logic [1:0] field, input logic action);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx; cfg_valid = vld; cfg_ip = ip;
    cfg_prefix = prefix; cfg_field = field; cfg_action = action;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  // exp_rise: cycle offset from accept at which out_valid must be high.
  task automatic lookup(input string tag, input logic [31:0] s, input logic [31:0] d,
                        input logic eb, input logic eh, input logic [3:0] ei, input int exp_rise);
    int n;
    @(negedge clk);
    check_val({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    src_ip = s; dst_ip = d; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check_val({tag, ".latency"}, 32'(n + 1), 32'(exp_rise));
    check_val({tag, ".block"}, 32'(out_block), 32'(eb));
    check_val({tag, ".hit"}, 32'(out_hit), 32'(eh));
    check_val({tag, ".idx"}, 32'(out_rule_idx), 32'(ei));
    last_block = eb;
    $display("lookup %s src=%h dst=%h block=%0d hit=%0d idx=%0d rise=T+%0d",
             tag, s, d, out_block, out_hit, out_rule_idx, n + 1);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    if (exp_pkt != 32'hFFFF_FFFF) exp_pkt = exp_pkt + 32'd1;
    if (last_block && exp_blk != 32'hFFFF_FFFF) exp_blk = exp_blk + 32'd1;
    check_val({tag, ".hs_out_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, ".hs_in_ready"}, 32'(in_ready), 32'd1);
    check_val({tag, ".pkt_count"}, pkt_count, exp_pkt);
    check_val({tag, ".block_count"}, block_count, exp_blk);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    check_val({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, ".out_block"}, 32'(out_block), 32'd0);
    check_val({tag, ".out_hit"}, 32'(out_hit), 32'd0);
    check_val({tag, ".out_idx"}, 32'(out_rule_idx), 32'd0);
    check_val({tag, ".pkt_count"}, pkt_count, 32'd0);
    check_val({tag, ".block_count"}, block_count, 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; exp_pkt = 0; exp_blk = 0; last_block = 0;
    rst = 1'b1; in_valid = 1'b0; src_ip = '0; dst_ip = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_valid = 1'b0; cfg_ip = '0;
    cfg_prefix = '0; cfg_field = '0; cfg_action = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // Empty table: default permit after a full scan of 4 groups.
    lookup("empty", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 4'd0, 5);
    handshake("empty");

    cfg_write(4'd0, 1'b1, 32'hC0A8_0000, 6'd24, 2'b00, 1'b1);
    lookup("src24", 32'hC0A8_0005, 32'h0A00_0001, 1'b1, 1'b1, 4'd0, 2);
    handshake("src24");
    cfg_write(4'd0, 1'b0, 32'h0, 6'd0, 2'b00, 1'b0);

    // Priority between overlapping dst rules in different groups.
    cfg_write(4'd3, 1'b1, 32'h0A00_0000, 6'd8, 2'b01, 1'b0);
    cfg_write(4'd9, 1'b1, 32'h0A01_0000, 6'd16, 2'b01, 1'b1);
    lookup("prio3", 32'h0, 32'h0A01_0203, 1'b0, 1'b1, 4'd3, 2);
    handshake("prio3");
    cfg_write(4'd3, 1'b0, 32'h0, 6'd0, 2'b00, 1'b0);
    lookup("prio9", 32'h0, 32'h0A01_0203, 1'b1, 1'b1, 4'd9, 4);
    handshake("prio9");
    cfg_write(4'd9, 1'b0, 32'h0, 6'd0, 2'b00, 1'b0);

    // Field modes and prefix edge cases.
    cfg_write(4'd0, 1'b1, 32'hC0A8_0001, 6'd32, 2'b11, 1'b1);
    lookup("both_hit", 32'hC0A8_0001, 32'hC0A8_0001, 1'b1, 1'b1, 4'd0, 2);
    handshake("both_hit");
    lookup("both_miss", 32'hC0A8_0001, 32'hC0A8_0002, 1'b0, 1'b0, 4'd0, 5);
    handshake("both_miss");
    cfg_write(4'd0, 1'b1, 32'hDEAD_BEEF, 6'd0, 2'b00, 1'b1);
    lookup("pfx0", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, 4'd0, 2);
    handshake("pfx0");
    cfg_write(4'd0, 1'b1, 32'hC0A8_0001, 6'd40, 2'b01, 1'b1);
    lookup("pfx40_hit", 32'h0, 32'hC0A8_0001, 1'b1, 1'b1, 4'd0, 2);
    handshake("pfx40_hit");
    lookup("pfx40_miss", 32'h0, 32'hC0A8_0003, 1'b0, 1'b0, 4'd0, 5);
    handshake("pfx40_miss");
    cfg_write(4'd0, 1'b0, 32'h0, 6'd0, 2'b00, 1'b0);
    cfg_write(4'd5, 1'b1, 32'h0A00_0000, 6'd8, 2'b10, 1'b1);
    lookup("any_dst", 32'h0B00_0001, 32'h0A00_0009, 1'b1, 1'b1, 4'd5, 3);
    handshake("any_dst");
    lookup("any_none", 32'h0B00_0001, 32'h0C00_0009, 1'b0, 1'b0, 4'd0, 5);
    handshake("any_none");
    cfg_write(4'd5, 1'b0, 32'h0, 6'd0, 2'b00, 1'b0);

    // Backpressure: verdict held, counters frozen.
    cfg_write(4'd1, 1'b1, 32'h0, 6'd0, 2'b00, 1'b1);
    lookup("bp", 32'h0101_0101, 32'h0202_0202, 1'b1, 1'b1, 4'd1, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val("bp.out_valid", 32'(out_valid), 32'd1);
      check_val("bp.block", 32'(out_block), 32'd1);
      check_val("bp.idx", 32'(out_rule_idx), 32'd1);
      check_val("bp.in_ready", 32'(in_ready), 32'd0);
      check_val("bp.pkt_count", pkt_count, exp_pkt);
    end
    handshake("bp");
    cfg_write(4'd1, 1'b0, 32'h0, 6'd0, 2'b00, 1'b0);

    // Reset during SEARCH drops the request.
    @(negedge clk);
    src_ip = 32'h0505_0505; dst_ip = 32'h0606_0606; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_pkt = 0; exp_blk = 0;
    check_reset_state("midrst");
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 if (out_valid) seen_valid = 1'b1;
    end
    check_val("midrst.no_verdict", 32'(seen_valid), 32'd0);
    $display("midsearch reset: in_ready=%0d out_valid=%0d", in_ready, out_valid);

    // Saturation of the packet counter.
    cfg_write(4'd0, 1'b1, 32'h0, 6'd0, 2'b00, 1'b1);
    @(negedge clk);
    force dut.pkt_count_reg = 32'hFFFF_FFFE;
    release dut.pkt_count_reg;
    exp_pkt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      lookup("sat", 32'h0707_0707, 32'h0808_0808, 1'b1, 1'b1, 4'd0, 2);
      handshake("sat");
    end
    check_val("sat.pkt_final", pkt_count, 32'hFFFF_FFFF);
    check_val("sat.blk_final", block_count, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
